// File: rtl/fpu_ss_fcsr_ctrl.sv
// Floating-point CSR controller: executes fflags/frm/fcsr CSR ops, accrues FPU exception
// flags and orders fflags accesses after all in-flight FP operations.
module fpu_ss_fcsr_ctrl #(
  parameter int unsigned NUM_RES_PORTS   = 1,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned ID_WIDTH        = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       csr_valid_i,
  output logic                       csr_ready_o,
  input  logic [11:0]                csr_addr_i,
  input  logic [1:0]                 csr_op_i,
  input  logic                       csr_we_i,
  input  logic [31:0]                csr_wdata_i,
  input  logic [4:0]                 csr_rd_i,
  input  logic [ID_WIDTH-1:0]        csr_id_i,
  input  logic                       fpu_issue_i,
  input  logic [NUM_RES_PORTS-1:0]   fpu_done_i,
  input  logic [5*NUM_RES_PORTS-1:0] fpu_status_i,
  output logic                       issue_stall_o,
  output logic                       wb_valid_o,
  input  logic                       wb_ready_i,
  output logic [31:0]                wb_data_o,
  output logic [4:0]                 wb_addr_o,
  output logic [ID_WIDTH-1:0]        wb_id_o,
  output logic                       wb_err_o,
  output logic [2:0]                 frm_o,
  output logic [4:0]                 fflags_o
);

  localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned DW = $clog2(NUM_RES_PORTS + 1);
  localparam int unsigned SW = ((CW > DW) ? CW : DW) + 1;

  localparam logic [11:0] ADDR_FFLAGS = 12'h001;
  localparam logic [11:0] ADDR_FRM    = 12'h002;
  localparam logic [11:0] ADDR_FCSR   = 12'h003;

  localparam logic [1:0] OP_RW = 2'b00;
  localparam logic [1:0] OP_RS = 2'b01;
  localparam logic [1:0] OP_RC = 2'b10;

  typedef enum logic [1:0] {ST_IDLE, ST_DRAIN, ST_WB} state_e;

  state_e state_q, state_d;

  logic [7:0]          fcsr_q, fcsr_d;
  logic [CW-1:0]       pending_q, pending_d;
  logic [SW-1:0]       pending_sum;
  logic [SW-1:0]       done_cnt;
  logic [4:0]          acc_flags;

  logic [11:0]         req_addr_q;
  logic [1:0]          req_op_q;
  logic                req_we_q;
  logic [7:0]          req_wdata_q;
  logic [4:0]          req_rd_q;
  logic [ID_WIDTH-1:0] req_id_q;

  logic [31:0]         wb_data_q;
  logic [4:0]          wb_addr_q;
  logic [ID_WIDTH-1:0] wb_id_q;
  logic                wb_err_q;

  logic [11:0]         sel_addr;
  logic [1:0]          sel_op;
  logic                sel_we;
  logic [7:0]          sel_wdata;
  logic [4:0]          sel_rd;
  logic [ID_WIDTH-1:0] sel_id;

  logic                accept, touches_fflags, supported, commit;
  logic [7:0]          old8, mask8, new8;
  logic                unused_wdata;

  assign unused_wdata = ^csr_wdata_i[31:8];

  // In DRAIN the captured request is executed; in IDLE the live request commits directly.
  always_comb begin
    if (state_q == ST_DRAIN) begin
      sel_addr  = req_addr_q;
      sel_op    = req_op_q;
      sel_we    = req_we_q;
      sel_wdata = req_wdata_q;
      sel_rd    = req_rd_q;
      sel_id    = req_id_q;
    end else begin
      sel_addr  = csr_addr_i;
      sel_op    = csr_op_i;
      sel_we    = csr_we_i;
      sel_wdata = csr_wdata_i[7:0];
      sel_rd    = csr_rd_i;
      sel_id    = csr_id_i;
    end
  end

  assign accept         = (state_q == ST_IDLE) && csr_valid_i;
  assign touches_fflags = (sel_addr == ADDR_FFLAGS) || (sel_addr == ADDR_FCSR);
  assign supported      = ((sel_addr == ADDR_FFLAGS) || (sel_addr == ADDR_FRM) ||
                           (sel_addr == ADDR_FCSR)) && (sel_op != 2'b11);
  assign commit         = (accept && !(touches_fflags && (pending_q != '0))) ||
                          ((state_q == ST_DRAIN) && (pending_q == '0));

  always_comb begin
    acc_flags = '0;
    done_cnt  = '0;
    for (int unsigned p = 0; p < NUM_RES_PORTS; p++) begin
      if (fpu_done_i[p]) begin
        acc_flags = acc_flags | fpu_status_i[5*p +: 5];
        done_cnt  = done_cnt + SW'(1);
      end
    end
  end

  assign pending_sum = SW'(pending_q) + SW'(fpu_issue_i) - done_cnt;
  assign pending_d   = pending_sum[CW-1:0];

  always_comb begin
    old8  = '0;
    mask8 = '0;
    unique case (sel_addr)
      ADDR_FFLAGS: begin old8 = {3'b000, fcsr_q[4:0]};   mask8 = 8'h1F; end
      ADDR_FRM:    begin old8 = {5'b00000, fcsr_q[7:5]}; mask8 = 8'h07; end
      ADDR_FCSR:   begin old8 = fcsr_q;                  mask8 = 8'hFF; end
      default:     begin old8 = '0;                      mask8 = '0;    end
    endcase
    unique case (sel_op)
      OP_RW:   new8 = sel_wdata;
      OP_RS:   new8 = old8 | sel_wdata;
      OP_RC:   new8 = old8 & ~sel_wdata;
      default: new8 = old8;
    endcase
    new8 = new8 & mask8;
  end

  // fflags commits only happen with nothing in flight, so they never race accrual.
  always_comb begin
    fcsr_d      = fcsr_q;
    fcsr_d[4:0] = fcsr_q[4:0] | acc_flags;
    if (commit && supported && sel_we) begin
      unique case (sel_addr)
        ADDR_FFLAGS: fcsr_d[4:0] = new8[4:0];
        ADDR_FRM:    fcsr_d[7:5] = new8[2:0];
        ADDR_FCSR:   fcsr_d      = new8;
        default:     fcsr_d      = fcsr_d;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (commit) state_d = (!supported || (sel_rd != '0)) ? ST_WB : ST_IDLE;
          else        state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (commit) state_d = (!supported || (sel_rd != '0)) ? ST_WB : ST_IDLE;
      end
      ST_WB: begin
        if (wb_ready_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    csr_ready_o   = (state_q == ST_IDLE);
    wb_valid_o    = (state_q == ST_WB);
    issue_stall_o = (state_q != ST_IDLE) || (pending_q == CW'(MAX_OUTSTANDING));
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fcsr_q      <= '0;
      pending_q   <= '0;
      req_addr_q  <= '0;
      req_op_q    <= '0;
      req_we_q    <= 1'b0;
      req_wdata_q <= '0;
      req_rd_q    <= '0;
      req_id_q    <= '0;
      wb_data_q   <= '0;
      wb_addr_q   <= '0;
      wb_id_q     <= '0;
      wb_err_q    <= 1'b0;
    end else begin
      fcsr_q    <= fcsr_d;
      pending_q <= pending_d;
      if (accept) begin
        req_addr_q  <= csr_addr_i;
        req_op_q    <= csr_op_i;
        req_we_q    <= csr_we_i;
        req_wdata_q <= csr_wdata_i[7:0];
        req_rd_q    <= csr_rd_i;
        req_id_q    <= csr_id_i;
      end
      if (commit) begin
        wb_data_q <= supported ? {24'h000000, old8} : '0;
        wb_addr_q <= sel_rd;
        wb_id_q   <= sel_id;
        wb_err_q  <= !supported;
      end
    end
  end

  assign wb_data_o = wb_data_q;
  assign wb_addr_o = wb_addr_q;
  assign wb_id_o   = wb_id_q;
  assign wb_err_o  = wb_err_q;
  assign frm_o     = fcsr_q[7:5];
  assign fflags_o  = fcsr_q[4:0];

  a_no_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    done_cnt <= SW'(pending_q) + SW'(fpu_issue_i));
  a_no_done_when_empty: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (done_cnt != '0) |-> (pending_q != '0));
  // An issue against a stall is tolerated only when a completion frees a slot the same cycle.
  a_no_issue_when_stalled: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (fpu_issue_i && issue_stall_o) |-> (done_cnt != '0));
  a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    pending_sum <= SW'(MAX_OUTSTANDING));

endmodule

// File: tb/tb_fpu_ss_fcsr_ctrl.sv
// Self-checking bench for fpu_ss_fcsr_ctrl: directed cases followed by randomized CSR
// traffic against a field-level model of fflags/frm and an in-flight op count.
module tb_fpu_ss_fcsr_ctrl;

  localparam int unsigned NP  = 2;
  localparam int unsigned MAX = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        csr_valid;
  logic        csr_ready;
  logic [11:0] csr_addr;
  logic [1:0]  csr_op;
  logic        csr_we;
  logic [31:0] csr_wdata;
  logic [4:0]  csr_rd;
  logic [3:0]  csr_id;
  logic        fpu_issue;
  logic [NP-1:0]   fpu_done;
  logic [5*NP-1:0] fpu_status;
  logic        issue_stall;
  logic        wb_valid;
  logic        wb_ready;
  logic [31:0] wb_data;
  logic [4:0]  wb_addr;
  logic [3:0]  wb_id;
  logic        wb_err;
  logic [2:0]  frm;
  logic [4:0]  fflags;

  int checks   = 0;
  int failures = 0;

  int unsigned m_flags   = 0;
  int unsigned m_frm     = 0;
  int unsigned m_pending = 0;
  int unsigned dq[$];

  fpu_ss_fcsr_ctrl #(
    .NUM_RES_PORTS  (NP),
    .MAX_OUTSTANDING(MAX),
    .ID_WIDTH       (4)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .csr_valid_i  (csr_valid),
    .csr_ready_o  (csr_ready),
    .csr_addr_i   (csr_addr),
    .csr_op_i     (csr_op),
    .csr_we_i     (csr_we),
    .csr_wdata_i  (csr_wdata),
    .csr_rd_i     (csr_rd),
    .csr_id_i     (csr_id),
    .fpu_issue_i  (fpu_issue),
    .fpu_done_i   (fpu_done),
    .fpu_status_i (fpu_status),
    .issue_stall_o(issue_stall),
    .wb_valid_o   (wb_valid),
    .wb_ready_i   (wb_ready),
    .wb_data_o    (wb_data),
    .wb_addr_o    (wb_addr),
    .wb_id_o      (wb_id),
    .wb_err_o     (wb_err),
    .frm_o        (frm),
    .fflags_o     (fflags)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Advance one cycle, folding the currently driven FPU activity into the model.
  task automatic cyc();
    for (int p = 0; p < NP; p++) begin
      if (fpu_done[p]) begin
        m_flags   = m_flags | fpu_status[5*p +: 5];
        m_pending = m_pending - 1;
      end
    end
    if (fpu_issue) m_pending = m_pending + 1;
    @(negedge clk);
  endtask

  task automatic clear_fpu();
    fpu_issue  = 1'b0;
    fpu_done   = '0;
    fpu_status = '0;
  endtask

  function automatic void model_op(input int unsigned a, input int unsigned op,
                                   input bit we, input int unsigned wd,
                                   output int unsigned old_v, output bit err);
    int unsigned lim, w, nv;
    old_v = 0;
    err   = !((a >= 1 && a <= 3) && op != 3);
    if (err) return;
    case (a)
      1:       begin old_v = m_flags;            lim = 31;  end
      2:       begin old_v = m_frm;              lim = 7;   end
      default: begin old_v = m_frm * 32 + m_flags; lim = 255; end
    endcase
    w = wd & lim;
    case (op)
      0:       nv = w;
      1:       nv = old_v | w;
      default: nv = old_v & ~w & lim;
    endcase
    if (we) begin
      case (a)
        1:       m_flags = nv;
        2:       m_frm   = nv;
        default: begin m_frm = nv / 32; m_flags = nv % 32; end
      endcase
    end
  endfunction

  task automatic drive_done_random();
    int unsigned n;
    n = (m_pending >= 2) ? $urandom_range(1, 2) : 1;
    if (n == 2) fpu_done = 2'b11;
    else        fpu_done = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
    fpu_status = 10'($urandom_range(0, 1023));
  endtask

  task automatic issue_n(input int unsigned n);
    for (int i = 0; i < int'(n); i++) begin
      chk("stall_before_issue", {31'd0, issue_stall}, {31'd0, m_pending == MAX});
      if (m_pending < MAX) begin
        fpu_issue = 1'b1;
        cyc();
        clear_fpu();
      end
    end
  endtask

  task automatic retire_all();
    int guard = 0;
    while (m_pending > 0 && guard < 20) begin
      drive_done_random();
      cyc();
      clear_fpu();
      guard++;
    end
    chk("retire_pending_stall", {31'd0, issue_stall}, 32'd0);
  endtask

  task automatic csr_req(input logic [11:0] a, input logic [1:0] op, input logic we,
                         input logic [31:0] wd, input logic [4:0] rd, input logic [3:0] id,
                         input int unsigned rdly, input bit done_at_accept);
    int unsigned old_v;
    bit          err, drain, exp_wb;
    int          guard;
    chk("req_ready", {31'd0, csr_ready}, 32'd1);
    csr_valid = 1'b1; csr_addr = a; csr_op = op; csr_we = we;
    csr_wdata = wd;   csr_rd = rd;  csr_id = id;
    drain = ((a == 12'h001) || (a == 12'h003)) && (m_pending != 0);
    if (!drain) begin
      model_op(int'(a), int'(op), we, wd, old_v, err);
      if (done_at_accept && m_pending > 0) begin
        fpu_done   = 2'b01;
        fpu_status = 10'($urandom_range(0, 31));
      end
      cyc();
      clear_fpu();
      csr_valid = 1'b0;
    end else begin
      cyc();
      csr_valid = 1'b0;
      guard = 0;
      while (m_pending > 0 && guard < 20) begin
        chk("drain_ready_low", {31'd0, csr_ready}, 32'd0);
        chk("drain_no_wb", {31'd0, wb_valid}, 32'd0);
        if (dq.size() > 0) begin
          int unsigned e;
          e = dq.pop_front();
          fpu_done = '0;
          fpu_done[e / 32] = 1'b1;
          fpu_status = '0;
          fpu_status[5*(e/32) +: 5] = 5'(e % 32);
        end else begin
          drive_done_random();
        end
        cyc();
        clear_fpu();
        guard++;
      end
      chk("drain_commit_cycle_no_wb", {31'd0, wb_valid}, 32'd0);
      model_op(int'(a), int'(op), we, wd, old_v, err);
      cyc();
    end
    exp_wb = err || (rd != 0);
    if (exp_wb) begin
      chk("wb_valid", {31'd0, wb_valid}, 32'd1);
      chk("wb_data", wb_data, old_v);
      chk("wb_addr", {27'd0, wb_addr}, {27'd0, rd});
      chk("wb_id", {28'd0, wb_id}, {28'd0, id});
      chk("wb_err", {31'd0, wb_err}, {31'd0, err});
      for (int i = 0; i < int'(rdly); i++) begin
        cyc();
        chk("wb_hold_valid", {31'd0, wb_valid}, 32'd1);
        chk("wb_hold_data", wb_data, old_v);
        chk("wb_hold_err", {31'd0, wb_err}, {31'd0, err});
      end
      wb_ready = 1'b1;
      cyc();
      wb_ready = 1'b0;
    end
    chk("after_wb_valid", {31'd0, wb_valid}, 32'd0);
    chk("after_ready", {31'd0, csr_ready}, 32'd1);
    chk("frm", {29'd0, frm}, m_frm);
    chk("fflags", {27'd0, fflags}, m_flags);
  endtask

  initial begin
    rst_n = 1'b0; csr_valid = 1'b0; csr_addr = '0; csr_op = '0; csr_we = 1'b0;
    csr_wdata = '0; csr_rd = '0; csr_id = '0; wb_ready = 1'b0;
    clear_fpu();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    chk("rst_ready", {31'd0, csr_ready}, 32'd1);
    chk("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    chk("rst_wb_addr", {27'd0, wb_addr}, 32'd0);
    chk("rst_wb_id", {28'd0, wb_id}, 32'd0);
    chk("rst_wb_err", {31'd0, wb_err}, 32'd0);
    chk("rst_stall", {31'd0, issue_stall}, 32'd0);
    chk("rst_frm", {29'd0, frm}, 32'd0);
    chk("rst_fflags", {27'd0, fflags}, 32'd0);

    // frm write with single-cycle writeback latency
    csr_req(12'h002, 2'b00, 1'b1, 32'd3, 5'd5, 4'd1, 0, 1'b0);
    chk("frm_is_3", {29'd0, frm}, 32'd3);

    // fflags read ordered behind two in-flight ops: NX on port0, then DZ on port1
    issue_n(2);
    dq.push_back(0 * 32 + 5'h01);
    dq.push_back(1 * 32 + 5'h08);
    csr_req(12'h001, 2'b01, 1'b0, 32'd0, 5'd7, 4'd2, 0, 1'b0);
    chk("drain_flags_9", {27'd0, fflags}, 32'h09);

    // fflags=0x1F, frm=0, then fcsr clear of bits 1/2
    csr_req(12'h001, 2'b00, 1'b1, 32'h1F, 5'd0, 4'd3, 0, 1'b0);
    csr_req(12'h002, 2'b00, 1'b1, 32'h00, 5'd2, 4'd4, 0, 1'b0);
    csr_req(12'h003, 2'b10, 1'b1, 32'h06, 5'd4, 4'd5, 0, 1'b0);
    chk("rc_fflags_19", {27'd0, fflags}, 32'h19);

    // saturated in-flight count with simultaneous issue and completion
    issue_n(MAX);
    chk("stall_at_max", {31'd0, issue_stall}, 32'd1);
    fpu_issue = 1'b1; fpu_done = 2'b01; fpu_status = 10'h004;
    cyc();
    clear_fpu();
    chk("stall_stays_max", {31'd0, issue_stall}, 32'd1);
    retire_all();

    // unsupported address with a slow writeback consumer
    csr_req(12'h300, 2'b00, 1'b1, 32'hFFFF_FFFF, 5'd9, 4'd6, 3, 1'b0);

    // reset while draining drops the request
    csr_req(12'h002, 2'b00, 1'b1, 32'd5, 5'd1, 4'd7, 0, 1'b0);
    issue_n(1);
    csr_valid = 1'b1; csr_addr = 12'h001; csr_op = 2'b01; csr_we = 1'b0;
    csr_wdata = '0; csr_rd = 5'd3; csr_id = 4'd8;
    cyc();
    csr_valid = 1'b0;
    chk("in_drain_ready_low", {31'd0, csr_ready}, 32'd0);
    rst_n = 1'b0;
    m_flags = 0; m_frm = 0; m_pending = 0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("drain_rst_ready", {31'd0, csr_ready}, 32'd1);
    chk("drain_rst_fflags", {27'd0, fflags}, 32'd0);
    chk("drain_rst_frm", {29'd0, frm}, 32'd0);
    chk("drain_rst_stall", {31'd0, issue_stall}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("drain_rst_no_wb", {31'd0, wb_valid}, 32'd0);
    end

    // randomized traffic
    for (int t = 0; t < 60; t++) begin
      logic [11:0] a;
      logic [4:0]  rd;
      issue_n($urandom_range(0, MAX));
      case ($urandom_range(0, 4))
        0: a = 12'h001;
        1: a = 12'h002;
        2: a = 12'h003;
        3: a = 12'h300;
        default: a = 12'($urandom);
      endcase
      rd = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      csr_req(a, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), $urandom, rd,
              4'($urandom), $urandom_range(0, 2), 1'($urandom_range(0, 1)));
      retire_all();
      chk("rand_fflags_after_retire", {27'd0, fflags}, m_flags);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
